// File: rtl/if_stage_pkg.sv
// Shared definitions for the fetch stage and the ID-stage control unit.
// Next-PC select codes, fetch FSM encoding and the bubble instruction word.
package if_stage_pkg;

    localparam logic [1:0] PCSRC_SEQ = 2'b00;
    localparam logic [1:0] PCSRC_BR  = 2'b01;
    localparam logic [1:0] PCSRC_JR  = 2'b10;
    localparam logic [1:0] PCSRC_J   = 2'b11;

    localparam logic [31:0] NOP_WORD = 32'h0000_0000;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_HOLD = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/if_stage_if.sv
// Instruction-memory req/ack port of the fetch stage.
// The master drives the request and address; the memory answers with ack and data.
interface if_stage_if;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );

endinterface

// File: rtl/if_stage_npc_mux4.sv
// Combinational 32-bit 4:1 mux choosing the next-PC candidate by pcsource.
module npc_mux4
    import if_stage_pkg::*;
(
    input  logic [1:0]  sel,
    input  logic [31:0] d_seq,
    input  logic [31:0] d_br,
    input  logic [31:0] d_jr,
    input  logic [31:0] d_j,
    output logic [31:0] y
);

    always_comb begin
        y = d_seq;
        case (sel)
            PCSRC_BR: y = d_br;
            PCSRC_JR: y = d_jr;
            PCSRC_J:  y = d_j;
            default:  y = d_seq;
        endcase
    end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, runs the imem req/ack handshake and
// loads the IF/ID register, with load-use stall and a one-instruction delay slot.
//
// state  | meaning
// S_IDLE | first cycle after reset, no request yet
// S_REQ  | request outstanding at pc, waiting for ack
// S_HOLD | word fetched during a stall, parked in hold_inst
module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = NOP_WORD
) (
    input  logic               clock,
    input  logic               resetn,
    input  logic [1:0]         pcsource,
    input  logic [31:0]        bpc,
    input  logic [31:0]        rpc,
    input  logic [31:0]        jpc,
    input  logic               wpcir,
    if_stage_if.master         imem,
    output logic [31:0]        pc,
    output logic [31:0]        dpc4,
    output logic [31:0]        dinst,
    output logic               dvalid
);

    fetch_state_t state;
    logic         redir_valid;
    logic [31:0]  redir_pc;
    logic [31:0]  hold_inst;
    logic [31:0]  pc4;
    logic [31:0]  target;
    logic [31:0]  npc;
    logic         redirect_now;

    assign pc4 = pc + 32'd4;

    npc_mux4 u_npc_mux4 (
        .sel   (pcsource),
        .d_seq (pc4),
        .d_br  (bpc),
        .d_jr  (rpc),
        .d_j   (jpc),
        .y     (target)
    );

    // A bubble in IF/ID means cu's pcsource is stale, so it is ignored.
    assign redirect_now = dvalid & wpcir & (pcsource != PCSRC_SEQ);
    assign npc          = redir_valid  ? redir_pc :
                          redirect_now ? target   : pc4;

    assign imem.imem_req  = (state == S_REQ);
    assign imem.imem_addr = pc;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state       <= S_IDLE;
            pc          <= RESET_PC;
            dpc4        <= 32'd0;
            dinst       <= NOP_INSTR;
            dvalid      <= 1'b0;
            redir_valid <= 1'b0;
            redir_pc    <= 32'd0;
            hold_inst   <= 32'd0;
        end else begin
            case (state)
                S_IDLE: state <= S_REQ;
                S_REQ: begin
                    if (imem.imem_ack) begin
                        if (wpcir) begin
                            dpc4        <= pc4;
                            dinst       <= imem.imem_rdata;
                            dvalid      <= 1'b1;
                            pc          <= npc;
                            redir_valid <= 1'b0;
                        end else begin
                            hold_inst <= imem.imem_rdata;
                            state     <= S_HOLD;
                        end
                    end else if (wpcir) begin
                        dpc4   <= 32'd0;
                        dinst  <= NOP_INSTR;
                        dvalid <= 1'b0;
                        // The delay slot is still in flight: remember where to go after it.
                        if (redirect_now && !redir_valid) begin
                            redir_valid <= 1'b1;
                            redir_pc    <= target;
                        end
                    end
                end
                S_HOLD: begin
                    if (wpcir) begin
                        dpc4        <= pc4;
                        dinst       <= hold_inst;
                        dvalid      <= 1'b1;
                        pc          <= npc;
                        redir_valid <= 1'b0;
                        state       <= S_REQ;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: directed scenarios plus a randomized run
// compared against a transaction-level model of the fetch stage.
module tb_if_stage;
    import if_stage_pkg::*;

    logic        clock = 1'b0;
    logic        resetn = 1'b0;
    logic [1:0]  pcsource = 2'b00;
    logic [31:0] bpc = 32'd0, rpc = 32'd0, jpc = 32'd0;
    logic        wpcir = 1'b0;
    logic [31:0] pc, dpc4, dinst;
    logic        dvalid;
    int          n_checks = 0;
    int          n_pass = 0;

    if_stage_if bus ();

    if_stage dut (
        .clock    (clock),
        .resetn   (resetn),
        .pcsource (pcsource),
        .bpc      (bpc),
        .rpc      (rpc),
        .jpc      (jpc),
        .wpcir    (wpcir),
        .imem     (bus),
        .pc       (pc),
        .dpc4     (dpc4),
        .dinst    (dinst),
        .dvalid   (dvalid)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0] ^ 16'h5A3C, ~a[15:0]};
    endfunction

    assign bus.imem_rdata = mem_word(bus.imem_addr);

    // Model: phase 0 = not started, 1 = fetch pending at m_pc, 2 = word parked.
    int          m_phase;
    logic [31:0] m_pc, m_dpc4, m_dinst, m_park;
    logic        m_dvalid;
    logic [31:0] m_pend[$];

    task automatic model_reset();
        m_phase = 0; m_pc = 32'd0; m_dpc4 = 32'd0; m_dinst = 32'd0;
        m_dvalid = 1'b0; m_park = 32'd0; m_pend.delete();
    endtask

    task automatic model_step();
        bit          decided;
        bit          have_word;
        logic [31:0] tgt, word;
        decided = m_dvalid && wpcir && (pcsource != 2'b00);
        tgt = (pcsource == 2'b01) ? bpc : (pcsource == 2'b10) ? rpc : jpc;
        have_word = (m_phase == 2) || (m_phase == 1 && bus.imem_ack);
        word = (m_phase == 2) ? m_park : mem_word(m_pc);
        if (m_phase == 0) begin
            m_phase = 1;
        end else if (have_word && wpcir) begin
            m_dpc4 = m_pc + 32'd4; m_dinst = word; m_dvalid = 1'b1;
            if (m_pend.size() != 0) m_pc = m_pend.pop_front();
            else if (decided) m_pc = tgt;
            else m_pc = m_pc + 32'd4;
            m_pend.delete();
            m_phase = 1;
        end else if (have_word) begin
            m_park = word; m_phase = 2;
        end else if (m_phase == 1 && wpcir) begin
            m_dpc4 = 32'd0; m_dinst = 32'd0; m_dvalid = 1'b0;
            if (decided && m_pend.size() == 0) m_pend.push_back(tgt);
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic do_reset();
        @(negedge clock);
        resetn = 1'b0;
        @(negedge clock);
        model_reset();
        resetn = 1'b1;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clock);
        n_checks++; if (pc !== 32'h0) $display("FAIL reset_pc: got %h want %h", pc, 32'h0); else n_pass++;
        n_checks++; if (bus.imem_req !== 1'b0) $display("FAIL reset_req: got %b want 0", bus.imem_req); else n_pass++;
        n_checks++; if (dvalid !== 1'b0) $display("FAIL reset_dvalid: got %b want 0", dvalid); else n_pass++;
        n_checks++; if (dinst !== 32'h0) $display("FAIL reset_dinst: got %h want 0", dinst); else n_pass++;
        n_checks++; if (dpc4 !== 32'h0) $display("FAIL reset_dpc4: got %h want 0", dpc4); else n_pass++;
        n_checks++; if (dut.redir_valid !== 1'b0) $display("FAIL reset_redir: got %b want 0", dut.redir_valid); else n_pass++;
        n_checks++; if (dut.state !== S_IDLE) $display("FAIL reset_state: got %0d want %0d", dut.state, S_IDLE); else n_pass++;
        model_reset();
        resetn = 1'b1;
    endtask

    task automatic test_sequential();
        do_reset();
        bus.imem_ack = 1'b1; wpcir = 1'b1; pcsource = 2'b00;
        n_checks++; if (bus.imem_addr !== 32'h0) $display("FAIL seq_addr0: got %h want 0", bus.imem_addr); else n_pass++;
        tick();
        n_checks++; if (bus.imem_req !== 1'b1) $display("FAIL seq_req: got %b want 1", bus.imem_req); else n_pass++;
        n_checks++; if (dvalid !== 1'b0) $display("FAIL seq_dvalid_first: got %b want 0", dvalid); else n_pass++;
        for (int i = 1; i <= 5; i++) begin
            tick();
            n_checks++; if (bus.imem_addr !== 32'(4 * i)) $display("FAIL seq_addr: got %h want %h", bus.imem_addr, 32'(4 * i)); else n_pass++;
            n_checks++; if (dpc4 !== 32'(4 * i)) $display("FAIL seq_dpc4: got %h want %h", dpc4, 32'(4 * i)); else n_pass++;
            n_checks++; if (dinst !== mem_word(32'(4 * (i - 1)))) $display("FAIL seq_dinst: got %h want %h", dinst, mem_word(32'(4 * (i - 1)))); else n_pass++;
            n_checks++; if (dvalid !== 1'b1) $display("FAIL seq_dvalid: got %b want 1", dvalid); else n_pass++;
        end
    endtask

    task automatic test_branch();
        do_reset();
        bus.imem_ack = 1'b1; wpcir = 1'b1; pcsource = 2'b00;
        repeat (6) tick();
        n_checks++; if (dinst !== mem_word(32'h10)) $display("FAIL br_beq_in_id: got %h want %h", dinst, mem_word(32'h10)); else n_pass++;
        n_checks++; if (bus.imem_addr !== 32'h14) $display("FAIL br_slot_addr: got %h want 14", bus.imem_addr); else n_pass++;
        pcsource = PCSRC_BR; bpc = 32'h40;
        tick();
        pcsource = PCSRC_SEQ;
        n_checks++; if (pc !== 32'h40) $display("FAIL br_target_pc: got %h want 40", pc); else n_pass++;
        n_checks++; if (dinst !== mem_word(32'h14) || dvalid !== 1'b1) $display("FAIL br_slot_exec: got %h/%b want %h/1", dinst, dvalid, mem_word(32'h14)); else n_pass++;
        tick();
        n_checks++; if (dinst !== mem_word(32'h40)) $display("FAIL br_target_inst: got %h want %h", dinst, mem_word(32'h40)); else n_pass++;
        n_checks++; if (dpc4 !== 32'h44) $display("FAIL br_target_dpc4: got %h want 44", dpc4); else n_pass++;
    endtask

    task automatic test_jr_latency();
        do_reset();
        bus.imem_ack = 1'b1; wpcir = 1'b1; pcsource = 2'b00;
        repeat (3) tick();
        bus.imem_ack = 1'b0; pcsource = PCSRC_JR; rpc = 32'h100;
        tick();
        rpc = 32'h200;
        n_checks++; if (dvalid !== 1'b0) $display("FAIL jr_bubble1: got %b want 0", dvalid); else n_pass++;
        n_checks++; if (dut.redir_valid !== 1'b1) $display("FAIL jr_redir_valid: got %b want 1", dut.redir_valid); else n_pass++;
        n_checks++; if (pc !== 32'h8 || bus.imem_req !== 1'b1) $display("FAIL jr_wait_pc: got %h/%b want 8/1", pc, bus.imem_req); else n_pass++;
        tick();
        n_checks++; if (dvalid !== 1'b0) $display("FAIL jr_bubble2: got %b want 0", dvalid); else n_pass++;
        bus.imem_ack = 1'b1;
        tick();
        pcsource = PCSRC_SEQ;
        n_checks++; if (dinst !== mem_word(32'h8) || dvalid !== 1'b1) $display("FAIL jr_slot: got %h/%b want %h/1", dinst, dvalid, mem_word(32'h8)); else n_pass++;
        n_checks++; if (bus.imem_addr !== 32'h100) $display("FAIL jr_target_addr: got %h want 100", bus.imem_addr); else n_pass++;
        n_checks++; if (dut.redir_valid !== 1'b0) $display("FAIL jr_redir_clear: got %b want 0", dut.redir_valid); else n_pass++;
    endtask

    task automatic test_stall_hold();
        do_reset();
        bus.imem_ack = 1'b1; wpcir = 1'b1; pcsource = 2'b00;
        repeat (3) tick();
        wpcir = 1'b0;
        tick();
        n_checks++; if (dut.state !== S_HOLD) $display("FAIL hold_state: got %0d want %0d", dut.state, S_HOLD); else n_pass++;
        n_checks++; if (bus.imem_req !== 1'b0) $display("FAIL hold_req: got %b want 0", bus.imem_req); else n_pass++;
        tick();
        n_checks++; if (pc !== 32'h8 || dpc4 !== 32'h8) $display("FAIL hold_frozen: got %h/%h want 8/8", pc, dpc4); else n_pass++;
        n_checks++; if (dinst !== mem_word(32'h4)) $display("FAIL hold_dinst_frozen: got %h want %h", dinst, mem_word(32'h4)); else n_pass++;
        wpcir = 1'b1;
        tick();
        n_checks++; if (dinst !== mem_word(32'h8) || dpc4 !== 32'hC) $display("FAIL hold_release: got %h/%h want %h/c", dinst, dpc4, mem_word(32'h8)); else n_pass++;
        n_checks++; if (bus.imem_addr !== 32'hC || bus.imem_req !== 1'b1) $display("FAIL hold_next_fetch: got %h/%b want c/1", bus.imem_addr, bus.imem_req); else n_pass++;
    endtask

    task automatic test_wrap();
        do_reset();
        bus.imem_ack = 1'b1; wpcir = 1'b1; pcsource = 2'b00;
        repeat (2) tick();
        pcsource = PCSRC_J; jpc = 32'hFFFF_FFFC;
        tick();
        pcsource = PCSRC_SEQ;
        n_checks++; if (pc !== 32'hFFFF_FFFC) $display("FAIL wrap_jump_pc: got %h want fffffffc", pc); else n_pass++;
        tick();
        n_checks++; if (dpc4 !== 32'h0) $display("FAIL wrap_dpc4: got %h want 0", dpc4); else n_pass++;
        n_checks++; if (bus.imem_addr !== 32'h0) $display("FAIL wrap_addr: got %h want 0", bus.imem_addr); else n_pass++;
        n_checks++; if (dinst !== mem_word(32'hFFFF_FFFC)) $display("FAIL wrap_dinst: got %h want %h", dinst, mem_word(32'hFFFF_FFFC)); else n_pass++;
    endtask

    task automatic test_reset_mid_request();
        do_reset();
        bus.imem_ack = 1'b1; wpcir = 1'b1; pcsource = 2'b00;
        repeat (3) tick();
        bus.imem_ack = 1'b0; pcsource = PCSRC_BR; bpc = 32'h80;
        tick();
        n_checks++; if (dut.redir_valid !== 1'b1 || bus.imem_req !== 1'b1) $display("FAIL rst_mid_setup: got %b/%b want 1/1", dut.redir_valid, bus.imem_req); else n_pass++;
        #2 resetn = 1'b0;
        #1;
        n_checks++; if (pc !== 32'h0 || bus.imem_req !== 1'b0) $display("FAIL rst_mid_pc_req: got %h/%b want 0/0", pc, bus.imem_req); else n_pass++;
        n_checks++; if (dvalid !== 1'b0 || dut.redir_valid !== 1'b0) $display("FAIL rst_mid_valid: got %b/%b want 0/0", dvalid, dut.redir_valid); else n_pass++;
        @(negedge clock);
        model_reset();
        resetn = 1'b1; pcsource = PCSRC_SEQ;
        n_checks++; if (bus.imem_req !== 1'b0) $display("FAIL rst_mid_idle: got %b want 0", bus.imem_req); else n_pass++;
        tick();
        n_checks++; if (dut.state !== S_REQ || bus.imem_req !== 1'b1) $display("FAIL rst_mid_resume: got %0d/%b want %0d/1", dut.state, bus.imem_req, S_REQ); else n_pass++;
    endtask

    task automatic test_random();
        logic [31:0] r;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            n_checks++; if (pc !== m_pc) $display("FAIL rnd_pc cyc %0d: got %h want %h", c, pc, m_pc); else n_pass++;
            n_checks++; if (bus.imem_req !== (m_phase == 1)) $display("FAIL rnd_req cyc %0d: got %b want %b", c, bus.imem_req, m_phase == 1); else n_pass++;
            n_checks++; if (dvalid !== m_dvalid) $display("FAIL rnd_dvalid cyc %0d: got %b want %b", c, dvalid, m_dvalid); else n_pass++;
            n_checks++; if (dinst !== m_dinst) $display("FAIL rnd_dinst cyc %0d: got %h want %h", c, dinst, m_dinst); else n_pass++;
            n_checks++; if (dpc4 !== m_dpc4) $display("FAIL rnd_dpc4 cyc %0d: got %h want %h", c, dpc4, m_dpc4); else n_pass++;
            bus.imem_ack = ($urandom_range(0, 9) < 6);
            wpcir = ($urandom_range(0, 3) != 0);
            pcsource = ($urandom_range(0, 9) < 7) ? 2'b00 : 2'($urandom_range(1, 3));
            r = $urandom; r[1:0] = 2'b00; bpc = r;
            r = $urandom; r[1:0] = 2'b00; rpc = r;
            r = $urandom; r[1:0] = 2'b00; jpc = r;
            tick();
        end
    endtask

    initial begin
        bus.imem_ack = 1'b0;
        model_reset();
        test_reset();
        test_sequential();
        test_branch();
        test_jr_latency();
        test_stall_hold();
        test_wrap();
        test_reset_mid_request();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage of the five-stage pipelined computer.
- Holds the PC and runs a req/ack handshake to the instruction memory.
- Picks the next PC from the pcsource select produced by the ID-stage control unit (cu), and loads the IF/ID pipeline register.
- Supports load-use stall (wpcir), variable-latency memory and a one-instruction branch delay slot.

Parameters:
- RESET_PC, 32'h0000_0000, fetch address after reset.
- NOP_INSTR, 32'h0000_0000, instruction word injected as a bubble.

Ports:
- clock  in  1  rising-edge clock
- resetn  in  1  reset, asynchronous, active-low
- pcsource  in  2  next-PC select from cu: 00 pc+4, 01 branch target, 10 jr register, 11 jump target
- bpc  in  32  branch target from ID
- rpc  in  32  jr register value from ID
- jpc  in  32  jump target from ID
- wpcir  in  1  1 = PC and IF/ID may advance; 0 = stall (hold)
- imem_req  out  1  fetch request
- imem_addr  out  32  fetch address (equals pc)
- imem_ack  in  1  rdata valid this cycle; sampled only while imem_req=1
- imem_rdata  in  32  fetched instruction
- pc  out  32  current fetch PC
- dpc4  out  32  IF/ID: PC+4 of held instruction
- dinst  out  32  IF/ID: instruction
- dvalid  out  1  IF/ID: 1 = real instruction, 0 = bubble

Behaviour:
- Reset (async, resetn=0):
  - Outputs: pc=RESET_PC, dpc4=0, dinst=NOP_INSTR, dvalid=0, imem_req=0.
  - Internal: state=S_IDLE, redir_valid=0, redir_pc=0, hold_inst=0.
  - A reset mid-request abandons the outstanding fetch. imem must tolerate req dropping without ack.
- Every register except the reset path updates on the rising edge of clock.
- FSM states:
  - S_IDLE: first cycle after reset, always goes to S_REQ.
  - S_REQ: imem_req=1, waiting for ack.
  - S_HOLD: instruction fetched while stalled, kept in hold_inst; imem_req=0.
- imem_req=1 only in S_REQ. imem_addr=pc always; pc changes only when a fetch completes, so the address is stable while req is high.
- Fetch completes when (S_REQ & imem_ack) | S_HOLD.
- redirect_now = dvalid & wpcir & (pcsource != 00). pcsource is ignored while wpcir=0 or dvalid=0.
- npc, by priority:
  1. redir_pc if redir_valid.
  2. Otherwise, if redirect_now, the target selected by pcsource (bpc/rpc/jpc).
  3. Otherwise pc+4.
  - All arithmetic is 32-bit, wrapping modulo 2^32.
- Delay slot: the instruction fetched at pc when a redirect is decided always executes. The target is fetched after it.
- Transitions in S_REQ:
  - ack=1, wpcir=1: IF/ID <= {pc+4, imem_rdata, 1}; pc <= npc; redir_valid <= 0; stay S_REQ. Zero-wait ack gives 1 instruction/cycle.
  - ack=1, wpcir=0: hold_inst <= imem_rdata; go S_HOLD; pc and IF/ID hold.
  - ack=0, wpcir=1: IF/ID <= {0, NOP_INSTR, 0} (bubble). If redirect_now: redir_valid <= 1 and redir_pc <= selected target.
  - ack=0, wpcir=0: everything holds.
- Transitions in S_HOLD:
  - wpcir=1: IF/ID <= {pc+4, hold_inst, 1}; pc <= npc; redir_valid <= 0; go S_REQ.
  - wpcir=0: stay.
- Redirect while redir_valid=1 cannot occur, because IF/ID holds a bubble. If it does, the pending redir_pc wins and the new request is dropped.
- Simultaneous redirect_now and completion: no capture; npc = target directly.

Decomposition:
- Shared package (also used by cu):
  - PCSRC_SEQ=2'b00, PCSRC_BR=2'b01, PCSRC_JR=2'b10, PCSRC_J=2'b11
  - FSM state encoding S_IDLE/S_REQ/S_HOLD
  - NOP word
- One sub-module: npc_mux4, a combinational 32-bit 4:1 mux indexed by pcsource.

Test Plan:
- Reset, then zero-wait memory (ack tied 1), wpcir=1:
  - imem_addr = 0, 4, 8, ... one per cycle.
  - dpc4 = 4, 8, ...; dvalid=1 from the 2nd edge.
- Beq at 0x10 with pcsource=01, bpc=0x40 while dinst is that beq:
  - Fetch order 0x14 (delay slot), then 0x40.
  - dinst for 0x14 has dvalid=1.
- Memory with 3-cycle ack latency, jr with rpc=0x100 decided during the wait:
  - IF/ID shows bubbles (dvalid=0) while waiting; redir_valid=1.
  - The delay-slot fetch completes, then imem_addr=0x100.
- wpcir=0 for 2 cycles with ack=1 at the first stalled cycle:
  - state goes to S_HOLD, imem_req=0, pc and IF/ID frozen.
  - On the wpcir=1 edge the held word appears in dinst, and the next fetch is at pc+4.
- pc=0xFFFF_FFFC sequential fetch: dpc4=0 and next imem_addr=0 (wrap).
- resetn low mid-request (req=1, ack=0):
  - Immediately pc=RESET_PC, imem_req=0, dvalid=0, redir_valid=0.
  - S_REQ resumes one cycle after release.
